irq_priority_sched: RTL and testbench

- Sequential front end for the 27-channel priority interrupt encoder datapath: three request buses (A, B, C) of 9 channels each.
- Captures request edges into pending latches, qualifies them with per-channel enables, and arbitrates by fixed priority.
- Presents one winner at a time to the CPU side over an irq/ack/eoi handshake.
- Adds an acknowledge timeout so that a lost ack cannot stall the controller.

---
 rtl/irq_sched_pkg.sv | 20 ++
 rtl/irq_prio_enc.sv | 47 ++++
 rtl/irq_priority_sched.sv | 158 +++++++++++++++
 tb/tb_irq_priority_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_sched_pkg.sv
// Shared definitions for the interrupt priority scheduler.
// Holds bus count and codes, field widths and the scheduler state type.
package irq_sched_pkg;

    localparam int NUM_BUS = 3;
    localparam int BUS_W   = 2;
    localparam int CHAN_W  = 4;
    localparam int PCNT_W  = 5;

    localparam logic [BUS_W-1:0] BUS_A = 2'd0;
    localparam logic [BUS_W-1:0] BUS_B = 2'd1;
    localparam logic [BUS_W-1:0] BUS_C = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder over three eligible vectors.
// Bus A beats B, B beats C; inside a bus the lowest channel index wins.
// Ports:
//   elig_a/b/c  in   eligible channels per bus
//   any_valid   out  at least one eligible channel
//   bus         out  winning bus code (BUS_A/BUS_B/BUS_C)
//   chan        out  winning channel index
module irq_prio_enc
    import irq_sched_pkg::*;
#(
    parameter int NUM_CH = 9
) (
    input  logic [NUM_CH-1:0] elig_a,
    input  logic [NUM_CH-1:0] elig_b,
    input  logic [NUM_CH-1:0] elig_c,
    output logic              any_valid,
    output logic [BUS_W-1:0]  bus,
    output logic [CHAN_W-1:0] chan
);

    // Scans downwards so the last hit, i.e. the lowest set index, is kept.
    function automatic logic [CHAN_W-1:0] lowest_idx(input logic [NUM_CH-1:0] v);
        logic [CHAN_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) idx = CHAN_W'(i);
        end
        return idx;
    endfunction

    always_comb begin
        any_valid = (|elig_a) | (|elig_b) | (|elig_c);
        bus       = BUS_A;
        chan      = '0;
        if (|elig_a) begin
            bus  = BUS_A;
            chan = lowest_idx(elig_a);
        end else if (|elig_b) begin
            bus  = BUS_B;
            chan = lowest_idx(elig_b);
        end else if (|elig_c) begin
            bus  = BUS_C;
            chan = lowest_idx(elig_c);
        end
    end

endmodule

// File: rtl/irq_priority_sched.sv
// Sequential front end of the 27-channel priority interrupt encoder.
// Captures request edges into pending bits, qualifies them with chan_en,
// picks a fixed-priority winner and presents it over irq/ack/eoi, with an
// ack timeout so a lost ack cannot stall the controller.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_a/b/c          request levels, bus A highest priority
//   chan_en            per-channel enable shared by all buses
//   int_ack, int_eoi   CPU accept / end of service
//   irq, irq_bus,      presented interrupt and its bus/channel
//   irq_chan
//   busy               in ASSERT or SERVICE
//   timeout            sticky ack-timeout flag
//   pending_cnt        registered popcount of all pending bits
//
// state   | meaning
// IDLE    | no interrupt outstanding, winner picked when one is eligible
// ASSERT  | irq high, waiting for int_ack or timeout
// SERVICE | acknowledged, waiting for int_eoi
module irq_priority_sched
    import irq_sched_pkg::*;
#(
    parameter int NUM_CH      = 9,
    parameter int ACK_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req_a,
    input  logic [NUM_CH-1:0] req_b,
    input  logic [NUM_CH-1:0] req_c,
    input  logic [NUM_CH-1:0] chan_en,
    input  logic              int_ack,
    input  logic              int_eoi,
    output logic              irq,
    output logic [BUS_W-1:0]  irq_bus,
    output logic [CHAN_W-1:0] irq_chan,
    output logic              busy,
    output logic              timeout,
    output logic [PCNT_W-1:0] pending_cnt
);

    logic [NUM_BUS-1:0][NUM_CH-1:0] req_all;
    logic [NUM_BUS-1:0][NUM_CH-1:0] req_s_q, req_h_q;
    logic [NUM_BUS-1:0][NUM_CH-1:0] pend_q, pend_d, clr, edge_det;
    logic [PCNT_W-1:0]              pcnt_q, pcnt_d;

    state_t            state_q, state_d;
    logic [BUS_W-1:0]  bus_q, bus_d;
    logic [CHAN_W-1:0] chan_q, chan_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              ack_clr;

    logic              win_valid;
    logic [BUS_W-1:0]  win_bus;
    logic [CHAN_W-1:0] win_chan;

    assign req_all  = {req_c, req_b, req_a};
    assign edge_det = req_s_q & ~req_h_q;

    irq_prio_enc #(.NUM_CH(NUM_CH)) u_enc (
        .elig_a    (pend_q[0] & chan_en),
        .elig_b    (pend_q[1] & chan_en),
        .elig_c    (pend_q[2] & chan_en),
        .any_valid (win_valid),
        .bus       (win_bus),
        .chan      (win_chan)
    );

    // Clearing the acknowledged winner; a coincident new edge re-sets it.
    always_comb begin
        clr = '0;
        for (int b = 0; b < NUM_BUS; b++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                clr[b][i] = ack_clr && (bus_q == BUS_W'(b)) && (chan_q == CHAN_W'(i));
            end
        end
        pend_d = (pend_q & ~clr) | edge_det;
    end

    always_comb begin
        pcnt_d = '0;
        for (int b = 0; b < NUM_BUS; b++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pcnt_d = pcnt_d + PCNT_W'(pend_q[b][i]);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bus_d     = bus_q;
        chan_d    = chan_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        ack_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    bus_d   = win_bus;
                    chan_d  = win_chan;
                    cnt_d   = '0;
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (int_ack) begin
                    ack_clr = 1'b1;
                    state_d = SERVICE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SERVICE: begin
                if (int_eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // During reset the history follows the live request level, so a line
    // already high when reset releases counts as old and needs a toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_s_q   <= req_all;
            req_h_q   <= req_all;
            pend_q    <= '0;
            pcnt_q    <= '0;
            state_q   <= IDLE;
            bus_q     <= BUS_A;
            chan_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            req_s_q   <= req_all;
            req_h_q   <= req_s_q;
            pend_q    <= pend_d;
            pcnt_q    <= pcnt_d;
            state_q   <= state_d;
            bus_q     <= bus_d;
            chan_q    <= chan_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign irq         = (state_q == ASSERT);
    assign busy        = (state_q != IDLE);
    assign irq_bus     = bus_q;
    assign irq_chan    = chan_q;
    assign timeout     = timeout_q;
    assign pending_cnt = pcnt_q;

endmodule

// File: tb/tb_irq_priority_sched.sv
module tb_irq_priority_sched;

    localparam int NUM_CH      = 9;
    localparam int ACK_TIMEOUT = 64;
    localparam int CNT_W       = 7;

    localparam int PH_IDLE    = 0;
    localparam int PH_PRESENT = 1;
    localparam int PH_SERVICE = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] req_a, req_b, req_c, chan_en;
    logic              int_ack, int_eoi;
    logic              irq;
    logic [1:0]        irq_bus;
    logic [3:0]        irq_chan;
    logic              busy, timeout;
    logic [4:0]        pending_cnt;

    int checks   = 0;
    int failures = 0;

    irq_priority_sched #(
        .NUM_CH(NUM_CH), .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .chan_en(chan_en),
        .int_ack(int_ack), .int_eoi(int_eoi),
        .irq(irq), .irq_bus(irq_bus), .irq_chan(irq_chan),
        .busy(busy), .timeout(timeout), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: request levels seen one and two clocks ago, pending
    // set, and what the CPU side currently sees.
    typedef bit bits_t [3][NUM_CH];
    bits_t m_seen1, m_seen2, m_pend;
    int    m_phase = PH_IDLE;
    int    m_bus = 0, m_chan = 0, m_shown = 0, m_to = 0, m_cnt = 0;

    function automatic bit req_bit(int b, int i);
        case (b)
            0:       return req_a[i];
            1:       return req_b[i];
            default: return req_c[i];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bits_t nxt;
        int    wb, wc, total;
        wb = -1; wc = -1; total = 0;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < NUM_CH; i++) begin
                total += int'(m_pend[b][i]);
                if (wb < 0 && m_pend[b][i] && chan_en[i]) begin
                    wb = b; wc = i;
                end
            end
        if (rst) begin
            for (int b = 0; b < 3; b++)
                for (int i = 0; i < NUM_CH; i++) begin
                    m_seen1[b][i] = req_bit(b, i);
                    m_seen2[b][i] = req_bit(b, i);
                    m_pend[b][i]  = 1'b0;
                end
            m_phase = PH_IDLE; m_bus = 0; m_chan = 0; m_shown = 0; m_to = 0; m_cnt = 0;
            return;
        end
        nxt = m_pend;
        if (m_phase == PH_PRESENT && int_ack) nxt[m_bus][m_chan] = 1'b0;
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_seen1[b][i] && !m_seen2[b][i]) nxt[b][i] = 1'b1;
                m_seen2[b][i] = m_seen1[b][i];
                m_seen1[b][i] = req_bit(b, i);
            end
        if (m_phase == PH_IDLE) begin
            if (wb >= 0) begin
                m_phase = PH_PRESENT; m_bus = wb; m_chan = wc; m_shown = 0;
            end
        end else if (m_phase == PH_PRESENT) begin
            if (int_ack) m_phase = PH_SERVICE;
            else begin
                m_shown++;
                if (m_shown == ACK_TIMEOUT) begin
                    m_phase = PH_IDLE; m_to = 1;
                end
            end
        end else if (int_eoi) begin
            m_phase = PH_IDLE;
        end
        m_pend = nxt;
        m_cnt  = total;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("m_irq",      32'(irq),         32'(m_phase == PH_PRESENT));
        chk("m_busy",     32'(busy),        32'(m_phase != PH_IDLE));
        chk("m_irq_bus",  32'(irq_bus),     32'(m_bus));
        chk("m_irq_chan", 32'(irq_chan),    32'(m_chan));
        chk("m_timeout",  32'(timeout),     32'(m_to));
        chk("m_pcnt",     32'(pending_cnt), 32'(m_cnt));
    endtask

    task automatic set_req(input int b, input int i, input logic v);
        case (b)
            0:       req_a[i] = v;
            1:       req_b[i] = v;
            default: req_c[i] = v;
        endcase
    endtask

    task automatic ack_then_eoi();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        int_eoi = 1'b1; tick(); int_eoi = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_a = '0; req_b = '0; req_c = '0; chan_en = '1;
        int_ack = 1'b0; int_eoi = 1'b0;
        tick(); tick();
        chk("rst_irq",  32'(irq), 0);
        chk("rst_bus",  32'(irq_bus), 0);
        chk("rst_chan", 32'(irq_chan), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pcnt", 32'(pending_cnt), 0);
        rst = 1'b0; tick();

        // Simultaneous A/C requests.
        set_req(2, 0, 1'b1); set_req(0, 5, 1'b1); tick();
        set_req(2, 0, 1'b0); set_req(0, 5, 1'b0); tick();
        chk("t1_irq_early", 32'(irq), 0);
        tick();
        chk("t1_irq", 32'(irq), 1);
        chk("t1_bus", 32'(irq_bus), 0);
        chk("t1_chan", 32'(irq_chan), 5);
        chk("t1_pcnt2", 32'(pending_cnt), 2);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("t1_irq_after_ack", 32'(irq), 0);
        tick();
        chk("t1_pcnt1", 32'(pending_cnt), 1);
        int_eoi = 1'b1; tick(); int_eoi = 1'b0;
        tick();
        chk("t1_b2b_irq", 32'(irq), 1);
        chk("t1_b2b_bus", 32'(irq_bus), 2);
        chk("t1_b2b_chan", 32'(irq_chan), 0);
        ack_then_eoi();
        chk("t1_pcnt0", 32'(pending_cnt), 0);

        // Masked channel.
        chan_en = ~NUM_CH'(1 << 3);
        set_req(1, 3, 1'b1); tick(); set_req(1, 3, 1'b0);
        tick(); tick(); tick();
        chk("t2_masked_irq", 32'(irq), 0);
        chk("t2_masked_pcnt", 32'(pending_cnt), 1);
        chan_en = '1; tick();
        chk("t2_irq", 32'(irq), 1);
        chk("t2_bus", 32'(irq_bus), 1);
        chk("t2_chan", 32'(irq_chan), 3);
        ack_then_eoi();

        // No preemption.
        set_req(2, 4, 1'b1); tick(); set_req(2, 4, 1'b0); tick(); tick();
        chk("t3_bus", 32'(irq_bus), 2);
        chk("t3_chan", 32'(irq_chan), 4);
        set_req(0, 0, 1'b1); tick(); set_req(0, 0, 1'b0);
        tick(); tick(); tick();
        chk("t3_hold_irq", 32'(irq), 1);
        chk("t3_hold_bus", 32'(irq_bus), 2);
        chk("t3_hold_chan", 32'(irq_chan), 4);
        ack_then_eoi(); tick();
        chk("t3_next_bus", 32'(irq_bus), 0);
        chk("t3_next_chan", 32'(irq_chan), 0);
        ack_then_eoi();

        // Ack timeout.
        set_req(1, 7, 1'b1); tick(); set_req(1, 7, 1'b0); tick(); tick();
        chk("t4_irq", 32'(irq), 1);
        chk("t4_pcnt", 32'(pending_cnt), 1);
        for (int k = 1; k < ACK_TIMEOUT; k++) tick();
        chk("t4_irq_last", 32'(irq), 1);
        tick();
        chk("t4_irq_drop", 32'(irq), 0);
        chk("t4_timeout", 32'(timeout), 1);
        tick();
        chk("t4_reassert", 32'(irq), 1);
        chk("t4_re_bus", 32'(irq_bus), 1);
        chk("t4_re_chan", 32'(irq_chan), 7);
        chk("t4_re_pcnt", 32'(pending_cnt), 1);
        ack_then_eoi();

        // Set-wins race between ack clear and a new edge.
        set_req(0, 2, 1'b1); tick(); set_req(0, 2, 1'b0); tick(); tick();
        chk("t5_chan", 32'(irq_chan), 2);
        set_req(0, 2, 1'b1); tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0; set_req(0, 2, 1'b0);
        tick();
        chk("t5_still_pending", 32'(pending_cnt), 1);
        int_eoi = 1'b1; tick(); int_eoi = 1'b0; tick();
        chk("t5_again_irq", 32'(irq), 1);
        chk("t5_again_bus", 32'(irq_bus), 0);
        chk("t5_again_chan", 32'(irq_chan), 2);
        ack_then_eoi();

        // Reset mid-service with a held-high request.
        set_req(0, 1, 1'b1); set_req(1, 1, 1'b1); set_req(2, 1, 1'b1); set_req(1, 8, 1'b1);
        tick();
        set_req(0, 1, 1'b0); set_req(1, 1, 1'b0); set_req(2, 1, 1'b0);
        tick(); tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0; tick();
        chk("t6_pcnt3", 32'(pending_cnt), 3);
        chk("t6_busy_svc", 32'(busy), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_irq", 32'(irq), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_pcnt", 32'(pending_cnt), 0);
        chk("t6_timeout", 32'(timeout), 0);
        tick(); tick(); tick(); tick();
        chk("t6_held_no_pend", 32'(pending_cnt), 0);
        set_req(1, 8, 1'b0); tick();
        set_req(1, 8, 1'b1); tick(); tick(); tick();
        chk("t6_toggle_irq", 32'(irq), 1);
        chk("t6_toggle_chan", 32'(irq_chan), 8);
        set_req(1, 8, 1'b0);
        ack_then_eoi();

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 2400; cyc++) begin
            int ack_pct;
            ack_pct = (cyc < 1200) ? 30 : 1;
            req_a = req_a ^ (NUM_CH'($urandom) & NUM_CH'($urandom) & NUM_CH'($urandom));
            req_b = req_b ^ (NUM_CH'($urandom) & NUM_CH'($urandom) & NUM_CH'($urandom));
            req_c = req_c ^ (NUM_CH'($urandom) & NUM_CH'($urandom) & NUM_CH'($urandom));
            if ($urandom_range(0, 15) == 0) chan_en = ~(NUM_CH'($urandom) & NUM_CH'($urandom));
            int_ack = ($urandom_range(0, 99) < ack_pct);
            int_eoi = ($urandom_range(0, 99) < 30);
            rst     = ($urandom_range(0, 399) == 0);
            tick();
        end

        rst = 1'b0; int_ack = 1'b0; int_eoi = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
